// File: rtl/exe_pkg.sv
// exe_pkg: shared opcodes, FSM state type and datapath width
// for the execute-stage controller.
package exe_pkg;

    localparam int EXE_DW = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NAND = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_BR   = 4'h9;
    localparam logic [3:0] OP_BRC  = 4'hA;
    localparam logic [3:0] OP_LDI  = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_IN_WAIT,
        S_OUT_WAIT
    } state_t;

    // Ops whose ALU result is written back at the end of EXEC.
    function automatic logic is_wb_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
               (op == OP_SHL) || (op == OP_SHR) || (op == OP_MOV);
    endfunction

endpackage

// File: rtl/exe_flags.sv
// exe_flags: Z/N flag register with per-op update rules and
// BR.Z/N condition evaluation against the current flags.
module exe_flags
    import exe_pkg::*;
#(
    parameter int DW = EXE_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upd_i,
    input  logic [3:0]    op_i,
    input  logic          a_msb_i,
    input  logic          a_lsb_i,
    input  logic [DW-1:0] res_i,
    input  logic          cond_i,
    output logic          flag_z_o,
    output logic          flag_n_o,
    output logic          cond_hit_o
);

    logic z_q, z_d;
    logic n_q, n_d;

    // Next flag values: only arithmetic/logic/shift ops touch the flags.
    always_comb begin
        z_d = z_q;
        n_d = n_q;
        if (upd_i) begin
            unique case (op_i)
                OP_ADD, OP_SUB, OP_NAND: begin
                    z_d = (res_i == '0);
                    n_d = res_i[DW-1];
                end
                OP_SHL: begin
                    z_d = (res_i == '0);
                    n_d = a_msb_i;
                end
                OP_SHR: begin
                    z_d = (res_i == '0);
                    n_d = a_lsb_i;
                end
                default: ;
            endcase
        end
    end

    // Flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            n_q <= n_d;
        end
    end

    assign flag_z_o   = z_q;
    assign flag_n_o   = n_q;
    assign cond_hit_o = cond_i ? n_q : z_q;

endmodule

// File: rtl/exe_ctrl.sv
// exe_ctrl: execute-stage FSM driving the external ALU, port handshakes
// and write-back. Optional IN wait timeout: EXE_IN_TIMEOUT_EN.
module exe_ctrl
    import exe_pkg::*;
#(
    parameter int DW             = EXE_DW,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [1:0]    in_rd,
    input  logic          in_cond,
    output logic [3:0]    alu_mode,
    output logic [DW-1:0] alu_s1,
    output logic [DW-1:0] alu_s2,
    input  logic [DW-1:0] alu_result,
    input  logic          port_in_valid,
    input  logic [DW-1:0] port_in_data,
    output logic          port_in_ack,
    output logic          port_out_valid,
    output logic [DW-1:0] port_out_data,
    input  logic          port_out_ready,
    output logic          wb_valid,
    output logic [1:0]    wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          br_taken,
    output logic          flag_z,
    output logic          flag_n,
    output logic          in_timeout
);

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [1:0]    rd_q, rd_d;
    logic          cond_q, cond_d;
    logic          wbv_q, wbv_d;
    logic [1:0]    wbrd_q, wbrd_d;
    logic [DW-1:0] wbd_q, wbd_d;
    logic          br_q, br_d;
    logic          ack_q, ack_d;
    logic          pov_q, pov_d;
    logic [DW-1:0] pod_q, pod_d;
    logic          flag_upd;
    logic          cond_hit;
    logic          to_hit;

`ifdef EXE_IN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             to_q;

    // Wait counter: zero outside IN_WAIT, counts idle cycles inside it.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_IN_WAIT) begin
            cnt_q <= '0;
        end else if (!port_in_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Timeout pulse; port data on the expiry cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= 1'b0;
        end else begin
            to_q <= (state_q == S_IN_WAIT) && to_hit;
        end
    end

    assign to_hit =
        !port_in_valid && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign in_timeout = to_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign to_hit     = 1'b0;
    assign in_timeout = 1'b0;
`endif

    exe_flags #(.DW(DW)) u_flags (
        .clk        (clk),
        .rst        (rst),
        .upd_i      (flag_upd),
        .op_i       (op_q),
        .a_msb_i    (a_q[DW-1]),
        .a_lsb_i    (a_q[0]),
        .res_i      (alu_result),
        .cond_i     (cond_q),
        .flag_z_o   (flag_z),
        .flag_n_o   (flag_n),
        .cond_hit_o (cond_hit)
    );

    // Next-state, ALU drive and registered-output next values.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        cond_d   = cond_q;
        wbv_d    = 1'b0;
        wbrd_d   = wbrd_q;
        wbd_d    = wbd_q;
        br_d     = 1'b0;
        ack_d    = 1'b0;
        pov_d    = pov_q;
        pod_d    = pod_q;
        flag_upd = 1'b0;
        alu_mode = OP_NOP;
        alu_s1   = a_q;
        alu_s2   = b_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    rd_d    = in_rd;
                    cond_d  = in_cond;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_mode = op_q;
                flag_upd = 1'b1;
                state_d  = S_IDLE;
                if (is_wb_op(op_q)) begin
                    wbv_d  = 1'b1;
                    wbrd_d = rd_q;
                    wbd_d  = alu_result;
                end else begin
                    unique case (op_q)
                        OP_OUT: begin
                            pov_d   = 1'b1;
                            pod_d   = alu_result;
                            state_d = S_OUT_WAIT;
                        end
                        OP_IN:          state_d = S_IN_WAIT;
                        OP_BR:          br_d = 1'b1;
                        OP_BRC:         br_d = cond_hit;
                        OP_NOP, OP_LDI: ;
                        default:        ;
                    endcase
                end
            end
            S_IN_WAIT: begin
                alu_mode = OP_IN;
                alu_s1   = port_in_data;
                if (port_in_valid) begin
                    ack_d   = 1'b1;
                    wbv_d   = 1'b1;
                    wbrd_d  = rd_q;
                    wbd_d   = alu_result;
                    a_d     = port_in_data;
                    state_d = S_IDLE;
                end else if (to_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_OUT_WAIT: begin
                if (port_out_ready) begin
                    pov_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            cond_q  <= 1'b0;
            wbv_q   <= 1'b0;
            wbrd_q  <= '0;
            wbd_q   <= '0;
            br_q    <= 1'b0;
            ack_q   <= 1'b0;
            pov_q   <= 1'b0;
            pod_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            cond_q  <= cond_d;
            wbv_q   <= wbv_d;
            wbrd_q  <= wbrd_d;
            wbd_q   <= wbd_d;
            br_q    <= br_d;
            ack_q   <= ack_d;
            pov_q   <= pov_d;
            pod_q   <= pod_d;
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign wb_valid       = wbv_q;
    assign wb_rd          = wbrd_q;
    assign wb_data        = wbd_q;
    assign br_taken       = br_q;
    assign port_in_ack    = ack_q;
    assign port_out_valid = pov_q;
    assign port_out_data  = pod_q;

endmodule

// File: tb/tb_exe_ctrl.sv
// tb_exe_ctrl: directed stimulus for exe_ctrl with a queue-based
// scoreboard; a negedge monitor pops expectations on each output event.
module tb_exe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [7:0] in_a, in_b;
    logic [1:0] in_rd;
    logic       in_cond;
    logic [3:0] alu_mode;
    logic [7:0] alu_s1, alu_s2, alu_result;
    logic       port_in_valid;
    logic [7:0] port_in_data;
    logic       port_in_ack;
    logic       port_out_valid;
    logic [7:0] port_out_data;
    logic       port_out_ready;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       br_taken;
    logic       flag_z, flag_n;
    logic       in_timeout;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] d;
        logic       z;
        logic       n;
        logic       ack;
        int         stamp;
    } wb_t;

    typedef struct {
        logic z;
        logic n;
        int   stamp;
    } br_t;

    wb_t wbq[$];
    br_t brq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_cnt = 0;
    int to_cnt  = 0;
    int acc;

    exe_ctrl #(.DW(8), .TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_rd          (in_rd),
        .in_cond        (in_cond),
        .alu_mode       (alu_mode),
        .alu_s1         (alu_s1),
        .alu_s2         (alu_s2),
        .alu_result     (alu_result),
        .port_in_valid  (port_in_valid),
        .port_in_data   (port_in_data),
        .port_in_ack    (port_in_ack),
        .port_out_valid (port_out_valid),
        .port_out_data  (port_out_data),
        .port_out_ready (port_out_ready),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .br_taken       (br_taken),
        .flag_z         (flag_z),
        .flag_n         (flag_n),
        .in_timeout     (in_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU the controller sequences.
    always_comb begin
        case (alu_mode)
            4'h1:    alu_result = alu_s1 + alu_s2;
            4'h2:    alu_result = alu_s1 - alu_s2;
            4'h3:    alu_result = ~(alu_s1 & alu_s2);
            4'h4:    alu_result = alu_s1 << 1;
            4'h5:    alu_result = alu_s1 >> 1;
            default: alu_result = alu_s1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (wbq.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_data), 32'hFFFF_FFFF);
                end else begin
                    wb_t e;
                    e = wbq.pop_front();
                    chk("wb", {19'd0, wb_rd, wb_data, flag_z, flag_n,
                               port_in_ack},
                        {19'd0, e.rd, e.d, e.z, e.n, e.ack});
                    if (e.stamp != 0) chk("wb_cycle", cyc, e.stamp);
                end
            end
            if (br_taken) begin
                if (brq.size() == 0) begin
                    chk("br_unexpected", 32'd1, 32'd0);
                end else begin
                    br_t b;
                    b = brq.pop_front();
                    chk("br", {30'd0, flag_z, flag_n}, {30'd0, b.z, b.n});
                    chk("br_cycle", cyc, b.stamp);
                end
            end
            if (port_in_ack) ack_cnt++;
            if (in_timeout)  to_cnt++;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] rd,
                         input logic cond);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        in_cond  = cond;
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic push_wb(input logic [1:0] rd, input logic [7:0] d,
                           input logic z, input logic n);
        wbq.push_back('{rd: rd, d: d, z: z, n: n, ack: 1'b0,
                        stamp: acc + 1});
    endtask

    task automatic push_br(input logic z, input logic n);
        brq.push_back('{z: z, n: n, stamp: acc + 1});
    endtask

    task automatic wait_pov(input string name);
        int n;
        n = 0;
        while (!port_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(port_out_valid), 32'd1);
    endtask

    task automatic chk_reset(input string name);
        chk(name, {14'd0, in_ready, wb_valid, br_taken, port_in_ack,
                   port_out_valid, flag_z, flag_n, in_timeout, wb_rd,
                   alu_mode, port_out_data == 8'd0, wb_data == 8'd0},
            {14'd0, 1'b1, 7'd0, 2'd0, 4'd0, 1'b1, 1'b1});
        chk({name, "_ops"}, {16'd0, alu_s1, alu_s2}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int a1;
        int n;
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_op          = 4'h0;
        in_a           = 8'h00;
        in_b           = 8'h00;
        in_rd          = 2'd0;
        in_cond        = 1'b0;
        port_in_valid  = 1'b0;
        port_in_data   = 8'h00;
        port_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset_state");
        rst = 1'b0;

        issue(4'h1, 8'h05, 8'hFB, 2'd1, 1'b0);
        push_wb(2'd1, 8'h00, 1'b1, 1'b0);
        a1 = acc;
        issue(4'hA, 8'h00, 8'h00, 2'd0, 1'b0);
        push_br(1'b1, 1'b0);
        chk("throughput", acc - a1, 2);

        issue(4'h2, 8'h03, 8'h07, 2'd2, 1'b0);
        push_wb(2'd2, 8'hFC, 1'b0, 1'b1);
        issue(4'hA, 8'h00, 8'h00, 2'd0, 1'b0);
        issue(4'hA, 8'h00, 8'h00, 2'd0, 1'b1);
        push_br(1'b0, 1'b1);

        issue(4'h3, 8'hFF, 8'hFF, 2'd3, 1'b0);
        push_wb(2'd3, 8'h00, 1'b1, 1'b0);
        issue(4'h4, 8'h81, 8'h00, 2'd0, 1'b0);
        push_wb(2'd0, 8'h02, 1'b0, 1'b1);
        issue(4'h0, 8'h00, 8'h00, 2'd1, 1'b0);
        issue(4'h8, 8'h00, 8'h55, 2'd1, 1'b0);
        push_wb(2'd1, 8'h00, 1'b0, 1'b1);
        issue(4'hB, 8'h00, 8'h00, 2'd2, 1'b0);
        issue(4'h5, 8'h02, 8'h00, 2'd2, 1'b0);
        push_wb(2'd2, 8'h01, 1'b0, 1'b0);
        issue(4'h9, 8'h00, 8'h00, 2'd0, 1'b0);
        push_br(1'b0, 1'b0);

        issue(4'h7, 8'h00, 8'h00, 2'd3, 1'b0);
        repeat (4) @(negedge clk);
        wbq.push_back('{rd: 2'd3, d: 8'h3C, z: 1'b0, n: 1'b0, ack: 1'b1,
                        stamp: 0});
        port_in_data  = 8'h3C;
        port_in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!port_in_ack && n < 20);
        chk("in_ack_seen", 32'(port_in_ack), 32'd1);
        port_in_valid = 1'b0;

        issue(4'h6, 8'hA5, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        wait_pov("out_valid_rise");
        for (int i = 0; i < 3; i++) begin
            chk("out_hold", {22'd0, port_out_valid, in_ready, port_out_data},
                {22'd0, 1'b1, 1'b0, 8'hA5});
            @(negedge clk);
        end
        port_out_ready = 1'b1;
        @(negedge clk);
        chk("out_release", {30'd0, port_out_valid, in_ready}, 32'd1);
        port_out_ready = 1'b0;

        issue(4'h2, 8'h03, 8'h07, 2'd2, 1'b0);
        push_wb(2'd2, 8'hFC, 1'b0, 1'b1);
        issue(4'h6, 8'h5A, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        wait_pov("out2_valid_rise");
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_out_wait");
        rst = 1'b0;

        issue(4'h2, 8'h03, 8'h07, 2'd1, 1'b0);
        push_wb(2'd1, 8'hFC, 1'b0, 1'b1);
        issue(4'h7, 8'h00, 8'h00, 2'd2, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_in_wait");
        rst = 1'b0;

`ifdef EXE_IN_TIMEOUT_EN
        issue(4'h7, 8'h00, 8'h00, 2'd1, 1'b0);
        a1 = acc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_timeout && n < 30);
        chk("timeout_cycle", cyc, a1 + 5);
        chk("timeout_idle", 32'(in_ready), 32'd1);
`endif

        repeat (5) @(negedge clk);
        chk("wbq_empty", wbq.size(), 0);
        chk("brq_empty", brq.size(), 0);
        chk("ack_count", ack_cnt, 1);
`ifdef EXE_IN_TIMEOUT_EN
        chk("timeout_count", to_cnt, 1);
`else
        chk("timeout_count", to_cnt, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
